// File: rtl/calc_input_ctrl.sv
// calc_input_ctrl: debounced two-operand entry and single-cycle ALU compute with display strobe
module calc_input_ctrl #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       opSel,
  input  logic             btnEnter,
  output logic [WIDTH-1:0] result,
  output logic             displayResult,
  output logic             carry,
  output logic [1:0]       state
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {WAIT_A = 2'b00, WAIT_B = 2'b01, COMPUTE = 2'b10, SHOW = 2'b11} state_t;
  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic              btn_db_q, btn_db_d;
  logic [CW-1:0]     db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic              carry_q, carry_d, disp_q, disp_d;
  logic              mism, done;
  logic [WIDTH:0]    sum, dif, op_res;
  // Synchronizer, debouncer and press edge detect; press is set on the edge btn_db rises
  always_comb begin
    sync_d   = {sync_q[0], btnEnter};
    mism     = sync_q[1] ^ btn_db_q;
    done     = mism && (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    btn_db_d = done ? ~btn_db_q : btn_db_q;
    db_cnt_d = (mism && !done) ? db_cnt_q + 1'b1 : '0;
    press_d  = done & ~btn_db_q;
  end
  // Operand capture, compute and strobe sequencing
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    disp_d   = 1'b0;
    sum      = {1'b0, a_q} + {1'b0, b_q};
    dif      = {1'b0, a_q} - {1'b0, b_q};
    op_res   = opSel == 2'b00 ? sum :
               opSel == 2'b01 ? dif :
               opSel == 2'b10 ? {1'b0, a_q & b_q} : {1'b0, a_q ^ b_q};
    case (state_q)
      WAIT_A: if (press_q) begin
        a_d      = sw;
        result_d = sw;
        disp_d   = 1'b1;
        state_d  = WAIT_B;
      end
      WAIT_B: if (press_q) begin
        b_d      = sw;
        result_d = sw;
        disp_d   = 1'b1;
        state_d  = COMPUTE;
      end
      COMPUTE: begin
        {carry_d, result_d} = op_res;
        disp_d              = 1'b1;
        state_d             = SHOW;
      end
      default: if (press_q) state_d = WAIT_A;
    endcase
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_A;
      sync_q   <= '0;
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      disp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      disp_q   <= disp_d;
    end
  end
  assign result        = result_q;
  assign displayResult = disp_q;
  assign carry         = carry_q;
  assign state         = state_q;
endmodule

// File: tb/tb_calc_input_ctrl.sv
// tb_calc_input_ctrl: scoreboard bench for operand entry, debounce, compute and reset
module tb_calc_input_ctrl;
  logic        clk = 0, rst = 1, btnEnter = 0, displayResult, carry;
  logic [15:0] sw = 0, result;
  logic [1:0]  opSel = 0, state;
  typedef struct {logic [15:0] r; logic c; bit cc; bit consec;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_strobe = 0, n_exp = 0, cyc = 0, last_cyc = -10;
  calc_input_ctrl #(.WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .opSel(opSel), .btnEnter(btnEnter),
    .result(result), .displayResult(displayResult), .carry(carry), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic push(input logic [15:0] r, input logic c, input bit cc, input bit consec);
    exp_t e;
    e.r = r; e.c = c; e.cc = cc; e.consec = consec;
    q.push_back(e);
    n_exp++;
  endtask
  task automatic press(input logic [15:0] v, input int hold);
    sw = v;
    btnEnter = 1;
    repeat (hold) @(negedge clk);
    btnEnter = 0;
    repeat (12) @(negedge clk);
  endtask
  task automatic sync_check(input string tag);
    chk({tag, "_strobes"}, n_strobe, n_exp);
    chk({tag, "_pending"}, q.size(), 0);
  endtask
  always @(negedge clk) if (!rst && displayResult) begin
    exp_t e;
    n_strobe++;
    if (q.size() == 0) chk("spurious_strobe", displayResult, 0);
    else begin
      e = q.pop_front();
      chk("result", result, e.r);
      if (e.cc) chk("carry", carry, e.c);
      if (e.consec) chk("consec", cyc - last_cyc, 1);
    end
    last_cyc = cyc;
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_state", state, 0);
    chk("rst_strobe", displayResult, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    opSel = 2'b00;
    push(16'hFFFF, 0, 0, 0); press(16'hFFFF, 12);
    chk("add_state_b", state, 1);
    push(16'h0001, 0, 0, 0); push(16'h0000, 1, 1, 1); press(16'h0001, 12);
    chk("add_state_show", state, 3);
    sync_check("add");
    press(16'h0000, 12);
    chk("show_exit_state", state, 0);
    sync_check("show_exit");
    sw = 16'hF0F0;
    for (int i = 0; i < 15; i++) begin
      btnEnter = ~btnEnter;
      repeat (2) @(negedge clk);
    end
    push(16'hF0F0, 0, 0, 0);
    btnEnter = 1;
    repeat (12) @(negedge clk);
    btnEnter = 0;
    repeat (12) @(negedge clk);
    chk("bounce_state", state, 1);
    sync_check("bounce");
    for (int i = 0; i < 4; i++) begin
      btnEnter = 1;
      repeat (3) @(negedge clk);
      btnEnter = 0;
      repeat (9) @(negedge clk);
    end
    chk("glitch_state", state, 1);
    sync_check("glitch");
    opSel = 2'b10;
    push(16'hFF00, 0, 0, 0); push(16'hF000, 0, 1, 1); press(16'hFF00, 12);
    opSel = 2'b11;
    repeat (10) @(negedge clk);
    chk("show_hold_result", result, 16'hF000);
    chk("show_hold_state", state, 3);
    sync_check("and");
    press(16'h0000, 12);
    chk("and_exit_state", state, 0);
    sync_check("and_exit");
    push(16'h00FF, 0, 0, 0); press(16'h00FF, 12);
    push(16'h0F0F, 0, 0, 0); push(16'h0FF0, 0, 1, 1); press(16'h0F0F, 12);
    sync_check("xor");
    press(16'h0000, 12);
    opSel = 2'b01;
    push(16'h0003, 0, 0, 0); press(16'h0003, 12);
    push(16'h0005, 0, 0, 0); push(16'hFFFE, 1, 1, 1); press(16'h0005, 12);
    press(16'h0000, 12);
    push(16'h0005, 0, 0, 0); press(16'h0005, 12);
    push(16'h0003, 0, 0, 0); push(16'h0002, 0, 1, 1); press(16'h0003, 12);
    sync_check("sub");
    press(16'h0000, 12);
    push(16'h1234, 0, 0, 0); press(16'h1234, 100);
    chk("hold_state", state, 1);
    sync_check("hold");
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_rst_result", result, 0);
    chk("async_rst_carry", carry, 0);
    chk("async_rst_state", state, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_state", state, 0);
    sync_check("post_rst");
    rst = 1;
    btnEnter = 1;
    repeat (2) @(negedge clk);
    push(16'h00AA, 0, 0, 0);
    sw = 16'h00AA;
    rst = 0;
    repeat (12) @(negedge clk);
    btnEnter = 0;
    repeat (12) @(negedge clk);
    chk("held_rst_state", state, 1);
    sync_check("held_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
